// File: rtl/u109_pci_pkg.sv
// Shared types, buffer-direction constants and parameter limits for the U109 PCI
// buffer sequencing blocks.
package u109_pci_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCpuAddr,
      StCpuData,
      StDmaAddr,
      StDmaData,
      StTurn
   } pci_state_e;

   localparam logic PCIDIR_TO_PCI   = 1'b1;
   localparam logic PCIDIR_TO_AMIGA = 1'b0;

   localparam int unsigned ADDR_CYCLES_MIN    = 1;
   localparam int unsigned ADDR_CYCLES_MAX    = 4;
   localparam int unsigned DEVSEL_TIMEOUT_MIN = 1;
   localparam int unsigned DEVSEL_TIMEOUT_MAX = 15;
   localparam int unsigned BURST_LEN_MIN      = 2;
   localparam int unsigned BURST_LEN_MAX      = 16;

   function automatic bit is_pow2(input int unsigned v);
      return (v != 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/pci_devsel_timer.sv
// Counts enabled cycles since the last clear; expired_o flags the enabled cycle that
// is the TIMEOUT-th one. The count saturates rather than wrapping.
module pci_devsel_timer #(
   parameter int unsigned TIMEOUT = 5
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != CntW'(TIMEOUT))) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign expired_o = enable_i && !clear_i && (cnt_q == CntW'(TIMEOUT - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pci_bus_sequencer.sv
// U109 A<->AD buffer sequencer: runs CPU cycles into PCI space and PCI-master DMA
// cycles into Amiga memory. Every output is a flop updated with the next state.
module pci_bus_sequencer
   import u109_pci_pkg::*;
#(
   parameter int unsigned ADDR_CYCLES    = 1,
   parameter int unsigned DEVSEL_TIMEOUT = 5,
   parameter int unsigned BURST_LEN      = 4,
   parameter int unsigned DMA_EN         = 1
) (
   input  logic CLK40,
   input  logic RESET,
   input  logic CPU_REQ,
   input  logic CPU_RW,
   input  logic CPU_BURST,
   input  logic FRAMEn,
   input  logic IRDYn,
   input  logic TRDYn,
   input  logic DEVSELn,
   input  logic STOPn,
   input  logic DMA_REQ,
   input  logic DMA_RW,
   input  logic LOCAL_ACK,
   output logic PCICYCLEn,
   output logic ADLATCH,
   output logic ALATCH,
   output logic PCIDIR,
   output logic CPU_ACK,
   output logic CPU_ERR,
   output logic CPU_RETRY,
   output logic BUSY
);

   if (ADDR_CYCLES < ADDR_CYCLES_MIN || ADDR_CYCLES > ADDR_CYCLES_MAX) begin : gen_bad_addr
      $error("ADDR_CYCLES out of range");
   end
   if (DEVSEL_TIMEOUT < DEVSEL_TIMEOUT_MIN || DEVSEL_TIMEOUT > DEVSEL_TIMEOUT_MAX)
   begin : gen_bad_timeout
      $error("DEVSEL_TIMEOUT out of range");
   end
   if (BURST_LEN < BURST_LEN_MIN || BURST_LEN > BURST_LEN_MAX || !is_pow2(BURST_LEN))
   begin : gen_bad_burst
      $error("BURST_LEN must be a power of 2 in range");
   end

   localparam int unsigned AddrCntW = $clog2(ADDR_CYCLES + 1);
   localparam int unsigned BeatCntW = $clog2(BURST_LEN + 1);

   pci_state_e state_q, state_d;
   logic [AddrCntW-1:0] addr_cnt_q, addr_cnt_d;
   logic [BeatCntW-1:0] beat_cnt_q, beat_cnt_d, beat_inc, beat_need;
   logic pcicycle_n_q, pcicycle_n_d, pcidir_q, pcidir_d;
   logic adlatch_q, adlatch_d, alatch_q, alatch_d;
   logic cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d, cpu_retry_q, cpu_retry_d;
   logic busy_q, busy_d;
   logic tmr_clear, tmr_enable, tmr_expired;
   logic dma_start, cpu_beat, dma_beat, last_beat, go_turn;

   assign tmr_clear  = (state_q == StCpuAddr);
   assign tmr_enable = (state_q == StCpuData) && DEVSELn;

   pci_devsel_timer #(
      .TIMEOUT(DEVSEL_TIMEOUT)
   ) u_devsel_timer (
      .clk_i    (CLK40),
      .rst_i    (RESET),
      .clear_i  (tmr_clear),
      .enable_i (tmr_enable),
      .expired_o(tmr_expired)
   );

   always_comb begin
      beat_need = CPU_BURST ? BeatCntW'(BURST_LEN) : BeatCntW'(1);
      beat_inc  = (beat_cnt_q == BeatCntW'(BURST_LEN)) ? beat_cnt_q : beat_cnt_q + 1'b1;
      last_beat = (beat_inc == beat_need);
      dma_start = (DMA_EN != 0) && DMA_REQ && !FRAMEn;
      cpu_beat  = !IRDYn && !TRDYn;
      dma_beat  = !IRDYn && LOCAL_ACK;

      state_d      = state_q;
      addr_cnt_d   = addr_cnt_q;
      beat_cnt_d   = beat_cnt_q;
      pcicycle_n_d = pcicycle_n_q;
      pcidir_d     = pcidir_q;
      adlatch_d    = 1'b0;
      alatch_d     = 1'b0;
      cpu_ack_d    = 1'b0;
      cpu_err_d    = 1'b0;
      cpu_retry_d  = 1'b0;
      go_turn      = 1'b0;

      case (state_q)
         StIdle: begin
            // DMA wins a tie; the CPU request simply stays pending
            if (dma_start) begin
               state_d      = StDmaAddr;
               pcicycle_n_d = 1'b0;
               pcidir_d     = PCIDIR_TO_AMIGA;
               alatch_d     = 1'b1;
            end else if (CPU_REQ) begin
               state_d      = StCpuAddr;
               pcicycle_n_d = 1'b0;
               pcidir_d     = PCIDIR_TO_PCI;
               addr_cnt_d   = '0;
               beat_cnt_d   = '0;
            end
         end
         StCpuAddr: begin
            if (addr_cnt_q == AddrCntW'(ADDR_CYCLES - 1)) begin
               state_d  = StCpuData;
               pcidir_d = CPU_RW ? PCIDIR_TO_AMIGA : PCIDIR_TO_PCI;
            end else begin
               addr_cnt_d = addr_cnt_q + 1'b1;
            end
         end
         StCpuData: begin
            if (!STOPn) begin
               if (DEVSELn) begin
                  cpu_err_d = 1'b1;
               end else begin
                  if (!TRDYn) begin
                     cpu_ack_d  = 1'b1;
                     adlatch_d  = CPU_RW;
                     beat_cnt_d = beat_inc;
                  end
                  cpu_retry_d = !(!TRDYn && last_beat);
               end
               go_turn = 1'b1;
            end else if (cpu_beat) begin
               cpu_ack_d  = 1'b1;
               adlatch_d  = CPU_RW;
               beat_cnt_d = beat_inc;
               go_turn    = last_beat;
            end else if (tmr_expired) begin
               cpu_err_d = 1'b1;
               go_turn   = 1'b1;
            end
         end
         StDmaAddr: begin
            state_d  = StDmaData;
            pcidir_d = DMA_RW ? PCIDIR_TO_PCI : PCIDIR_TO_AMIGA;
         end
         StDmaData: begin
            if (dma_beat) begin
               adlatch_d = !DMA_RW;
            end
            go_turn = (dma_beat && FRAMEn) || !DMA_REQ;
         end
         StTurn: begin
            state_d      = StIdle;
            pcicycle_n_d = 1'b1;
            pcidir_d     = PCIDIR_TO_AMIGA;
         end
         default: begin
            state_d      = StIdle;
            pcicycle_n_d = 1'b1;
            pcidir_d     = PCIDIR_TO_AMIGA;
         end
      endcase

      if (go_turn) begin
         state_d      = StTurn;
         pcicycle_n_d = 1'b1;
         pcidir_d     = PCIDIR_TO_AMIGA;
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge CLK40) begin
      if (RESET) begin
         state_q      <= StIdle;
         addr_cnt_q   <= '0;
         beat_cnt_q   <= '0;
         pcicycle_n_q <= 1'b1;
         pcidir_q     <= PCIDIR_TO_AMIGA;
         adlatch_q    <= 1'b0;
         alatch_q     <= 1'b0;
         cpu_ack_q    <= 1'b0;
         cpu_err_q    <= 1'b0;
         cpu_retry_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_cnt_q   <= addr_cnt_d;
         beat_cnt_q   <= beat_cnt_d;
         pcicycle_n_q <= pcicycle_n_d;
         pcidir_q     <= pcidir_d;
         adlatch_q    <= adlatch_d;
         alatch_q     <= alatch_d;
         cpu_ack_q    <= cpu_ack_d;
         cpu_err_q    <= cpu_err_d;
         cpu_retry_q  <= cpu_retry_d;
         busy_q       <= busy_d;
      end
   end

   assign PCICYCLEn = pcicycle_n_q;
   assign ADLATCH   = adlatch_q;
   assign ALATCH    = alatch_q;
   assign PCIDIR    = pcidir_q;
   assign CPU_ACK   = cpu_ack_q;
   assign CPU_ERR   = cpu_err_q;
   assign CPU_RETRY = cpu_retry_q;
   assign BUSY      = busy_q;

endmodule

// File: tb/tb_pci_bus_sequencer.sv
// Self-checking bench for pci_bus_sequencer: directed scenarios plus randomized CPU and
// DMA transactions, predicted per transaction from the cycle-level protocol rules.
module tb_pci_bus_sequencer;

   localparam int AC   = 1;
   localparam int TO   = 5;
   localparam int BL   = 4;
   localparam int MAXD = 32;

   logic CLK40 = 1'b0;
   logic RESET, CPU_REQ, CPU_RW, CPU_BURST;
   logic FRAMEn, IRDYn, TRDYn, DEVSELn, STOPn;
   logic DMA_REQ, DMA_RW, LOCAL_ACK;
   logic PCICYCLEn, ADLATCH, ALATCH, PCIDIR, CPU_ACK, CPU_ERR, CPU_RETRY, BUSY;

   int n_checks = 0;
   int n_errors = 0;

   // per data-cycle PCI responses for the next CPU transaction (index 1..MAXD)
   bit cv_n[0:MAXD];
   bit ct_n[0:MAXD];
   bit ci_n[0:MAXD];
   bit cs_n[0:MAXD];

   always #5 CLK40 = ~CLK40;

   pci_bus_sequencer #(
      .ADDR_CYCLES   (AC),
      .DEVSEL_TIMEOUT(TO),
      .BURST_LEN     (BL),
      .DMA_EN        (1)
   ) dut (
      .CLK40    (CLK40),
      .RESET    (RESET),
      .CPU_REQ  (CPU_REQ),
      .CPU_RW   (CPU_RW),
      .CPU_BURST(CPU_BURST),
      .FRAMEn   (FRAMEn),
      .IRDYn    (IRDYn),
      .TRDYn    (TRDYn),
      .DEVSELn  (DEVSELn),
      .STOPn    (STOPn),
      .DMA_REQ  (DMA_REQ),
      .DMA_RW   (DMA_RW),
      .LOCAL_ACK(LOCAL_ACK),
      .PCICYCLEn(PCICYCLEn),
      .ADLATCH  (ADLATCH),
      .ALATCH   (ALATCH),
      .PCIDIR   (PCIDIR),
      .CPU_ACK  (CPU_ACK),
      .CPU_ERR  (CPU_ERR),
      .CPU_RETRY(CPU_RETRY),
      .BUSY     (BUSY)
   );

   // {PCICYCLEn, ADLATCH, ALATCH, PCIDIR, CPU_ACK, CPU_ERR, CPU_RETRY, BUSY}
   function automatic logic [7:0] obs();
      return {PCICYCLEn, ADLATCH, ALATCH, PCIDIR, CPU_ACK, CPU_ERR, CPU_RETRY, BUSY};
   endfunction

   function automatic logic [7:0] mk(input bit pc, input bit lat, input bit al, input bit dir,
                                     input bit ack, input bit err, input bit ret, input bit busy);
      return {pc, lat, al, dir, ack, err, ret, busy};
   endfunction

   localparam logic [7:0] IdleVec = 8'b1000_0000;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b (PCICYCLEn,ADLATCH,ALATCH,PCIDIR,ACK,ERR,RETRY,BUSY)",
                  tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK40);
      #1;
   endtask

   task automatic pci_idle();
      FRAMEn = 1'b1; IRDYn = 1'b1; TRDYn = 1'b1; DEVSELn = 1'b1; STOPn = 1'b1;
      LOCAL_ACK = 1'b0;
   endtask

   task automatic fill_cpu_idle();
      for (int i = 0; i <= MAXD; i++) begin
         cv_n[i] = 1'b1; ct_n[i] = 1'b1; ci_n[i] = 1'b0; cs_n[i] = 1'b1;
      end
      cs_n[MAXD] = 1'b0;
   endtask

   task automatic rnd_cpu_stim();
      int dat;
      dat = $urandom_range(0, 6);
      for (int i = 0; i <= MAXD; i++) begin
         cv_n[i] = !(dat != 0 && i >= dat);
         ct_n[i] = cv_n[i] ? 1'b1 : 1'($urandom_range(0, 1));
         ci_n[i] = ($urandom_range(0, 9) < 2);
         cs_n[i] = ($urandom_range(0, 11) != 0);
      end
      cs_n[MAXD] = 1'b0;
   endtask

   // CPU transaction from IDLE; rst_at>0 asserts RESET during that data cycle.
   task automatic run_cpu(input bit rw, input bit burst, input int rst_at, input string name);
      bit ack_e[0:MAXD];
      bit lat_e[0:MAXD];
      bit err_e, ret_e, rst_hit;
      int need, beats, dev_hi, fin, last;
      need = burst ? BL : 1;
      beats = 0; dev_hi = 0; fin = 0; err_e = 0; ret_e = 0;
      for (int i = 0; i <= MAXD; i++) begin
         ack_e[i] = 1'b0; lat_e[i] = 1'b0;
      end
      for (int i = 1; i <= MAXD && fin == 0; i++) begin
         if (cv_n[i]) dev_hi++;
         if (!cs_n[i]) begin
            if (cv_n[i]) begin
               err_e = 1'b1;
            end else begin
               if (!ct_n[i]) begin
                  ack_e[i] = 1'b1; lat_e[i] = rw; beats++;
               end
               ret_e = !(!ct_n[i] && beats == need);
            end
            fin = i;
         end else if (!ci_n[i] && !ct_n[i]) begin
            ack_e[i] = 1'b1; lat_e[i] = rw; beats++;
            if (beats == need) fin = i;
         end else if (cv_n[i] && dev_hi == TO) begin
            err_e = 1'b1; fin = i;
         end
      end
      rst_hit = (rst_at != 0) && (rst_at <= fin);
      last = rst_hit ? rst_at : fin;

      DMA_REQ = 1'b0; pci_idle();
      CPU_REQ = 1'b1; CPU_RW = rw; CPU_BURST = burst;
      step();
      for (int a = 0; a < AC; a++) begin
         chk({name, " addr"}, obs(), mk(0, 0, 0, 1, 0, 0, 0, 1));
         step();
      end
      for (int i = 1; i <= last; i++) begin
         chk({name, " data"}, obs(), mk(0, lat_e[i-1], 0, !rw, ack_e[i-1], 0, 0, 1));
         DEVSELn = cv_n[i]; TRDYn = ct_n[i]; IRDYn = ci_n[i]; STOPn = cs_n[i];
         if (i == rst_at) RESET = 1'b1;
         step();
      end
      if (rst_hit) begin
         chk({name, " rst"}, obs(), IdleVec);
         RESET = 1'b0;
      end else begin
         chk({name, " turn"}, obs(), mk(1, lat_e[last], 0, 0, ack_e[last], err_e, ret_e, 1));
      end
      CPU_REQ = 1'b0; pci_idle();
      step();
      chk({name, " idle"}, obs(), IdleVec);
   endtask

   // DMA transaction from IDLE; with_cpu also raises CPU_REQ, left pending afterwards.
   task automatic run_dma(input bit rw, input int nbeats, input bit with_cpu, input bit rnd,
                          input string name);
      bit lat_e[0:MAXD];
      bit di_n[0:MAXD];
      bit dl[0:MAXD];
      bit df_n[0:MAXD];
      bit dr[0:MAXD];
      bit beat;
      int done, fin, pre;
      pre = (rnd && $urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : 0;
      done = 0; fin = 0;
      for (int j = 0; j <= MAXD; j++) begin
         lat_e[j] = 1'b0; di_n[j] = 1'b1; dl[j] = 1'b0; df_n[j] = 1'b1; dr[j] = 1'b1;
      end
      for (int j = 1; j <= MAXD && fin == 0; j++) begin
         di_n[j] = rnd ? ($urandom_range(0, 9) < 3) : 1'b0;
         dl[j]   = rnd ? ($urandom_range(0, 9) < 6) : 1'b1;
         if (j >= 20) begin
            di_n[j] = 1'b0; dl[j] = 1'b1;
         end
         df_n[j] = (done >= nbeats - 1);
         dr[j]   = (j != pre);
         beat = !di_n[j] && dl[j];
         lat_e[j] = beat && !rw;
         if (beat) done++;
         if ((beat && df_n[j]) || !dr[j]) fin = j;
      end

      pci_idle();
      DMA_REQ = 1'b1; FRAMEn = 1'b0; DMA_RW = rw;
      if (with_cpu) begin
         CPU_REQ = 1'b1; CPU_RW = 1'b0; CPU_BURST = 1'b0;
      end
      step();
      chk({name, " addr"}, obs(), mk(0, 0, 1, 0, 0, 0, 0, 1));
      step();
      for (int j = 1; j <= fin; j++) begin
         chk({name, " data"}, obs(), mk(0, lat_e[j-1], 0, rw, 0, 0, 0, 1));
         IRDYn = di_n[j]; LOCAL_ACK = dl[j]; FRAMEn = df_n[j]; DMA_REQ = dr[j];
         step();
      end
      chk({name, " turn"}, obs(), mk(1, lat_e[fin], 0, 0, 0, 0, 0, 1));
      DMA_REQ = 1'b0; pci_idle();
      step();
      chk({name, " idle"}, obs(), IdleVec);
   endtask

   initial begin
      RESET = 1'b1; CPU_REQ = 1'b0; CPU_RW = 1'b0; CPU_BURST = 1'b0;
      DMA_REQ = 1'b0; DMA_RW = 1'b0;
      pci_idle();
      step();
      step();
      chk("reset", obs(), IdleVec);
      RESET = 1'b0;
      step();
      chk("post_reset", obs(), IdleVec);

      fill_cpu_idle();
      for (int i = 2; i <= MAXD; i++) cv_n[i] = 1'b0;
      ct_n[3] = 1'b0;
      run_cpu(1'b0, 1'b0, 0, "t1_single_wr");

      fill_cpu_idle();
      for (int i = 1; i <= MAXD; i++) cv_n[i] = 1'b0;
      for (int i = 1; i <= 4; i++) ct_n[i] = 1'b0;
      run_cpu(1'b1, 1'b1, 0, "t2_burst_rd");

      fill_cpu_idle();
      run_cpu(1'b1, 1'b0, 0, "t3_mabort");

      fill_cpu_idle();
      for (int i = 1; i <= MAXD; i++) cv_n[i] = 1'b0;
      ct_n[1] = 1'b0; ct_n[2] = 1'b0; cs_n[2] = 1'b0;
      run_cpu(1'b0, 1'b1, 0, "t4_disconnect");

      run_dma(1'b0, 3, 1'b1, 1'b0, "t5_dma_wr");
      fill_cpu_idle();
      for (int i = 1; i <= MAXD; i++) cv_n[i] = 1'b0;
      ct_n[1] = 1'b0;
      run_cpu(1'b0, 1'b0, 0, "t5_cpu_after");

      fill_cpu_idle();
      for (int i = 1; i <= MAXD; i++) cv_n[i] = 1'b0;
      ct_n[1] = 1'b0;
      run_cpu(1'b1, 1'b1, 2, "t6_reset");
      fill_cpu_idle();
      for (int i = 1; i <= MAXD; i++) begin
         cv_n[i] = 1'b0; ct_n[i] = 1'b0;
      end
      run_cpu(1'b1, 1'b1, 0, "t6_fresh");

      for (int t = 0; t < 150; t++) begin
         bit cpu_too;
         int gap, rst_at;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            // DMA_REQ without FRAMEn must not start a DMA cycle
            DMA_REQ = 1'($urandom_range(0, 1)); FRAMEn = 1'b1;
            step();
            chk("rnd_gap", obs(), IdleVec);
         end
         DMA_REQ = 1'b0;
         if ($urandom_range(0, 2) == 0) begin
            cpu_too = 1'($urandom_range(0, 1));
            run_dma(1'($urandom_range(0, 1)), $urandom_range(1, 6), cpu_too, 1'b1, "rnd_dma");
            if (cpu_too) begin
               rnd_cpu_stim();
               run_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, "rnd_dma_cpu");
            end
         end else begin
            rnd_cpu_stim();
            rst_at = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 4) : 0;
            run_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rst_at, "rnd_cpu");
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
